npu_host_seq: RTL and testbench

Host-side initiator for the NPU memory-mapped port (ena/wea/addra/dina/douta). It consumes a packed byte stream and packs it little-endian into 32-bit words. It writes the image, conv1/conv2 weights and fc2 weights, pulses the trigger, then polls status and feeds fc1 weight words on request. It captures the signed 24-bit logit and sits between the host DMA/testbench byte source and the npu slave port.

---
 rtl/npu_host_seq_pkg.sv | 36 +++
 rtl/npu_host_seq_byte_packer.sv | 43 ++++
 rtl/npu_host_seq.sv | 195 +++++++++++++++++++
 tb/tb_npu_host_seq.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/npu_host_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : npu_host_pkg
// Description : Region select codes, status layout and sequencer states for
//               the NPU host-side initiator.
// Revision    : 1.0 - initial release
// ============================================================================
package npu_host_pkg;

  localparam logic [2:0] SEL_WC1  = 3'b001;
  localparam logic [2:0] SEL_WC2  = 3'b010;
  localparam logic [2:0] SEL_FC1  = 3'b011;
  localparam logic [2:0] SEL_FC2  = 3'b100;
  localparam logic [2:0] SEL_TRIG = 3'b101;
  localparam logic [2:0] SEL_IMG  = 3'b110;
  localparam logic [2:0] SEL_STAT = 3'b111;

  localparam int STAT_DONE_BIT    = 31;
  localparam int STAT_FC1_REQ_BIT = 30;
  localparam int LOGIT_W          = 24;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_IMG     = 4'd1,
    ST_WC1     = 4'd2,
    ST_WC2     = 4'd3,
    ST_FC2     = 4'd4,
    ST_TRIG    = 4'd5,
    ST_POLL_RD = 4'd6,
    ST_POLL_EV = 4'd7,
    ST_FC1_WR  = 4'd8,
    ST_FIN     = 4'd9
  } state_t;

endpackage
`default_nettype wire

// File: rtl/npu_host_seq_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : byte_packer
// Description : Four-byte little-endian word accumulator; a flush presents a
//               partial word with zero-filled upper bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_packer (
  input  logic        clk,
  input  logic        rst_ni,
  input  logic        in_en,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        flush,
  output logic        word_valid,
  output logic [31:0] word,
  input  logic        ack
);

  logic [2:0]  r_cnt;
  logic [31:0] r_buf;

  assign in_ready   = in_en && (r_cnt < 3'd4);
  assign word_valid = (r_cnt == 3'd4) || (flush && (r_cnt != 3'd0));
  assign word       = r_buf;

  // Clearing the buffer on ack is what provides the zero padding of a flush.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= 3'd0;
      r_buf <= 32'd0;
    end else if (ack) begin
      r_cnt <= 3'd0;
      r_buf <= 32'd0;
    end else if (in_valid && in_ready) begin
      r_buf[{r_cnt[1:0], 3'b000} +: 8] <= in_data;
      r_cnt                            <= r_cnt + 3'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/npu_host_seq.sv
`default_nettype none
// ============================================================================
// Module      : npu_host_seq
// Description : Host initiator that loads image/weights into the NPU, triggers
//               it, streams fc1 weights on request and captures the logit.
// Revision    : 1.0 - initial release
// ============================================================================
module npu_host_seq
  import npu_host_pkg::*;
#(
  parameter int IMG_BYTES    = 240,
  parameter int WC_BYTES     = 90,
  parameter int FC2_BYTES    = 10,
  parameter int FC1_WORDS    = 330,
  parameter int POLL_TIMEOUT = 65535
) (
  input  logic                clk,
  input  logic                rst_ni,
  input  logic                start,
  input  logic                s_valid,
  input  logic [7:0]          s_data,
  output logic                s_ready,
  output logic                npu_ena,
  output logic                npu_wea,
  output logic [15:0]         npu_addra,
  output logic [31:0]         npu_dina,
  input  logic [31:0]         npu_douta,
  output logic                busy,
  output logic                done,
  output logic [LOGIT_W-1:0]  result,
  output logic                err
);

  localparam int c_FC1_W = $clog2(FC1_WORDS + 1);
  localparam int c_TMO_W = $clog2(POLL_TIMEOUT + 1);
  localparam logic [c_FC1_W-1:0] c_FC1_MAX  = c_FC1_W'(FC1_WORDS);
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(POLL_TIMEOUT - 1);

  state_t               r_state, w_next, w_seg_next;
  logic [15:0]          r_bytes, w_seg_len;
  logic [11:0]          r_idx, w_idx;
  logic [c_FC1_W-1:0]   r_fc1;
  logic [c_TMO_W-1:0]   r_tmo;
  logic [LOGIT_W-1:0]   r_result;
  logic                 r_err;
  logic                 w_load, w_flush, w_pk_en, w_ack, w_word_valid, w_timeout;
  logic                 w_ena, w_wea;
  logic [2:0]           w_sel, w_seg_sel;
  logic [31:0]          w_word, w_dina;
  logic                 w_unused_stat;

  assign w_unused_stat = ^npu_douta[29:LOGIT_W];

  always_comb begin
    w_load     = 1'b1;
    w_seg_len  = 16'd0;
    w_seg_sel  = 3'b000;
    w_seg_next = r_state;
    case (r_state)
      ST_IMG:  begin w_seg_len = 16'(IMG_BYTES); w_seg_sel = SEL_IMG; w_seg_next = ST_WC1;  end
      ST_WC1:  begin w_seg_len = 16'(WC_BYTES);  w_seg_sel = SEL_WC1; w_seg_next = ST_WC2;  end
      ST_WC2:  begin w_seg_len = 16'(WC_BYTES);  w_seg_sel = SEL_WC2; w_seg_next = ST_FC2;  end
      ST_FC2:  begin w_seg_len = 16'(FC2_BYTES); w_seg_sel = SEL_FC2; w_seg_next = ST_TRIG; end
      default: w_load = 1'b0;
    endcase
  end

  // Segment exhausted: stop accepting and flush whatever partial word remains.
  assign w_flush = w_load && (r_bytes == w_seg_len);
  assign w_pk_en = (w_load && !w_flush) || (r_state == ST_FC1_WR);

  byte_packer u_packer (
    .clk        (clk),
    .rst_ni     (rst_ni),
    .in_en      (w_pk_en),
    .in_valid   (s_valid),
    .in_data    (s_data),
    .in_ready   (s_ready),
    .flush      (w_flush),
    .word_valid (w_word_valid),
    .word       (w_word),
    .ack        (w_ack)
  );

  always_comb begin
    w_next    = r_state;
    w_ena     = 1'b0;
    w_wea     = 1'b0;
    w_sel     = 3'b000;
    w_idx     = 12'd0;
    w_dina    = 32'd0;
    w_ack     = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_IMG;
      ST_IMG, ST_WC1, ST_WC2, ST_FC2: begin
        if (w_word_valid) begin
          w_ena  = 1'b1;
          w_wea  = 1'b1;
          w_sel  = w_seg_sel;
          w_idx  = r_idx;
          w_dina = w_word;
          w_ack  = 1'b1;
          if (w_flush) w_next = w_seg_next;
        end
      end
      ST_TRIG: begin
        w_ena  = 1'b1;
        w_wea  = 1'b1;
        w_sel  = SEL_TRIG;
        w_next = ST_POLL_RD;
      end
      ST_POLL_RD: begin
        w_ena  = 1'b1;
        w_sel  = SEL_STAT;
        w_next = ST_POLL_EV;
      end
      ST_POLL_EV: begin
        if (npu_douta[STAT_DONE_BIT])
          w_next = ST_FIN;
        else if (npu_douta[STAT_FC1_REQ_BIT] && (r_fc1 < c_FC1_MAX))
          w_next = ST_FC1_WR;
        else if (r_tmo == c_TMO_LAST) begin
          w_timeout = 1'b1;
          w_next    = ST_IDLE;
        end else
          w_next = ST_POLL_RD;
      end
      ST_FC1_WR: begin
        if (w_word_valid) begin
          w_ena  = 1'b1;
          w_wea  = 1'b1;
          w_sel  = SEL_FC1;
          w_dina = w_word;
          w_ack  = 1'b1;
          w_next = ST_POLL_RD;
        end
      end
      ST_FIN:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_bytes  <= 16'd0;
      r_idx    <= 12'd0;
      r_fc1    <= '0;
      r_tmo    <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_timeout;
      if ((r_state == ST_IDLE) && start) begin
        r_bytes <= 16'd0;
        r_idx   <= 12'd0;
        r_fc1   <= '0;
        r_tmo   <= '0;
      end
      if (w_load) begin
        if (w_ack && w_flush) begin
          r_bytes <= 16'd0;
          r_idx   <= 12'd0;
        end else if (w_ack)
          r_idx <= r_idx + 12'd1;
        else if (s_valid && s_ready)
          r_bytes <= r_bytes + 16'd1;
      end
      if ((r_state == ST_POLL_EV) && (w_next == ST_POLL_RD))
        r_tmo <= r_tmo + 1'b1;
      if ((r_state == ST_FC1_WR) && w_ack) begin
        r_fc1 <= r_fc1 + 1'b1;
        r_tmo <= '0;
      end
      if ((r_state == ST_POLL_EV) && npu_douta[STAT_DONE_BIT])
        r_result <= npu_douta[LOGIT_W-1:0];
    end
  end

  assign npu_ena   = w_ena;
  assign npu_wea   = w_wea;
  assign npu_addra = w_ena ? {1'b0, w_sel, w_idx} : 16'd0;
  assign npu_dina  = w_dina;
  assign busy      = (r_state != ST_IDLE) && (r_state != ST_FIN);
  assign done      = (r_state == ST_FIN);
  assign result    = r_result;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_npu_host_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_npu_host_seq
// Description : Directed/randomized bench for npu_host_seq with a stream-level
//               reference model of the expected NPU write sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_npu_host_seq;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'd0;
  logic [31:0] npu_douta = 32'd0;
  logic        s_ready, npu_ena, npu_wea, busy, done, err;
  logic [15:0] npu_addra;
  logic [31:0] npu_dina;
  logic [23:0] result;

  always #5 clk = ~clk;

  npu_host_seq #(.POLL_TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst_ni    (rst_ni),
    .start     (start),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .npu_ena   (npu_ena),
    .npu_wea   (npu_wea),
    .npu_addra (npu_addra),
    .npu_dina  (npu_dina),
    .npu_douta (npu_douta),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .err       (err)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  stream [0:4095];
  int          ptr;
  logic [15:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [15:0] got_addr[$];
  logic [31:0] got_data[$];
  int          polls, resp_idx, done_cnt, err_cnt, viol;
  int          stat_mode, n_req;
  logic [23:0] logit, exp_result;
  bit          toggle, read_pending;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // NPU status model: fc1_req for the first n_req polls, then done + logit.
  function automatic logic [31:0] status_word();
    logic [31:0] s;
    if (stat_mode == 0)
      s = 32'h0;
    else if (resp_idx < n_req)
      s = 32'h4000_0000 | 32'($urandom_range(0, 24'hFF_FFFF));
    else
      s = {2'b11, 6'h2A, logit};
    resp_idx++;
    return s;
  endfunction

  // Expected write list from the byte stream: segments chunked into padded
  // little-endian words, then the trigger, then fc1 words.
  task automatic build_expected(input int fc1_words);
    int          segl [4];
    logic [2:0]  segs [4];
    logic [31:0] d;
    int          p;
    segl = '{240, 90, 90, 10};
    segs = '{3'b110, 3'b001, 3'b010, 3'b100};
    p = 0;
    exp_addr.delete();
    exp_data.delete();
    for (int s = 0; s < 4; s++) begin
      for (int w = 0; w * 4 < segl[s]; w++) begin
        d = 32'd0;
        for (int b = 0; b < 4; b++)
          if (w * 4 + b < segl[s]) d[8*b +: 8] = stream[p + w * 4 + b];
        exp_addr.push_back({1'b0, segs[s], 12'(w)});
        exp_data.push_back(d);
      end
      p += segl[s];
    end
    exp_addr.push_back(16'h5000);
    exp_data.push_back(32'd0);
    for (int f = 0; f < fc1_words; f++) begin
      exp_addr.push_back(16'h3000);
      exp_data.push_back({stream[p + 3], stream[p + 2], stream[p + 1], stream[p]});
      p += 4;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    npu_douta    = read_pending ? status_word() : 32'h0;
    read_pending = 1'b0;
    if (npu_wea && !npu_ena) viol++;
    if (s_ready && !busy) viol++;
    if (npu_ena) begin
      if (npu_wea) begin
        got_addr.push_back(npu_addra);
        got_data.push_back(npu_dina);
      end else begin
        if (npu_addra !== 16'h7000) viol++;
        read_pending = 1'b1;
        polls++;
      end
    end
    if (done) done_cnt++;
    if (err) err_cnt++;
    s_valid = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
    s_data  = stream[ptr];
    if (s_valid && s_ready) ptr++;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ena"}, npu_ena, 1'b0);
    check({tag, "_wea"}, npu_wea, 1'b0);
    check({tag, "_addr"}, npu_addra, 16'h0);
    check({tag, "_dina"}, npu_dina, 32'h0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_rdy"}, s_ready, 1'b0);
    check({tag, "_result"}, result, 24'h0);
  endtask

  task automatic run_case(input string name, input bit tog, input bit rnd, input int mode,
                          input int nreq, input logic [23:0] lg, input bit inj_start,
                          input bit inj_rst, input bit fin_start);
    int cyc, nacc;
    bit fin;
    cyc = 0;
    fin = 1'b0;
    toggle = tog; stat_mode = mode; n_req = nreq; logit = lg;
    for (int i = 0; i < 4096; i++) stream[i] = rnd ? 8'($urandom) : 8'(i);
    ptr = 0; resp_idx = 0; polls = 0; done_cnt = 0; err_cnt = 0; viol = 0;
    got_addr.delete();
    got_data.delete();
    build_expected((mode == 0) ? 0 : ((nreq < 330) ? nreq : 330));
    start = 1'b1;
    step();
    start = 1'b0;
    check({name, "_busy_after_start"}, busy, 1'b1);
    while (!fin && cyc < 30000) begin
      step();
      cyc++;
      start = inj_start && (got_addr.size() == 88);
      if (done || err) begin
        fin = 1'b1;
        if (fin_start) start = 1'b1;
      end
      if (inj_rst && got_addr.size() == 115) begin
        rst_ni = 1'b0;
        #1;
        check_idle_outputs({name, "_in_reset"});
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        exp_result = 24'h0;
        nacc = got_addr.size() + polls;
        for (int k = 0; k < 40; k++) step();
        check({name, "_no_access_after_reset"}, got_addr.size() + polls, nacc);
        fin = 1'b1;
      end
    end
    check({name, "_finished_in_bound"}, cyc < 30000, 1'b1);
    step();
    start = 1'b0;
    check({name, "_idle_after_end"}, busy, 1'b0);
    for (int k = 0; k < 5; k++) step();

    if (inj_rst) begin
      check({name, "_writes_before_reset"}, got_addr.size(), 115);
    end else begin
      check({name, "_write_count"}, got_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
      check($sformatf("%s_addr[%0d]", name, i), got_addr[i], exp_addr[i]);
      check($sformatf("%s_data[%0d]", name, i), got_data[i], exp_data[i]);
    end
    check({name, "_protocol"}, viol, 0);
    if (mode == 0) begin
      check({name, "_err_pulses"}, err_cnt, 1);
      check({name, "_done_pulses"}, done_cnt, 0);
      check({name, "_polls"}, polls, TMO);
    end else if (!inj_rst) begin
      exp_result = lg;
      check({name, "_done_pulses"}, done_cnt, 1);
      check({name, "_err_pulses"}, err_cnt, 0);
    end else begin
      check({name, "_done_pulses"}, done_cnt, 0);
    end
    check({name, "_result"}, result, exp_result);
  endtask

  initial begin
    exp_result = 24'h0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_ni = 1'b1;
    step();

    run_case("seq_full", 1'b0, 1'b0, 1, 0, 24'h123456, 1'b0, 1'b0, 1'b1);
    check("img_word0", got_data[0], 32'h0302_0100);
    check("wc1_last_upper", got_data[82][31:16], 16'h0);
    run_case("seq_toggle", 1'b1, 1'b0, 1, 0, 24'h7ABCDE, 1'b0, 1'b0, 1'b0);
    run_case("fc1_330", 1'b1, 1'b1, 1, 330, 24'hFFFF85, 1'b0, 1'b0, 1'b0);
    run_case("timeout", 1'b1, 1'b1, 0, 0, 24'h000000, 1'b0, 1'b0, 1'b0);
    run_case("start_in_wc2", 1'b1, 1'b1, 1, 335, 24'($urandom), 1'b1, 1'b0, 1'b0);
    run_case("reset_in_fc1", 1'b1, 1'b1, 1, 400, 24'h055555, 1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
